led_response_scorer: RTL and testbench

Scores the player's response to the randomised game LED. It samples the LED state together with a raw push-button, debounces the button, and measures reaction time in milliseconds. Each lit-LED event is classified as a hit or a miss, and the block keeps saturating hit and miss tallies. It sits at the consuming end of the LED randomiser's output and drives the score display and round-control logic.

---
 rtl/led_game_pkg.sv | 25 ++
 rtl/button_debouncer.sv | 71 +++++++
 rtl/led_response_scorer.sv | 162 ++++++++++++++++
 tb/tb_led_response_scorer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_game_pkg.sv
// led_game_pkg: shared types, widths, saturation limits and saturating
// increment helpers for the LED reaction game scorer.
package led_game_pkg;

  localparam int COUNT_W = 10;
  localparam int RT_W    = 11;

  localparam logic [COUNT_W-1:0] COUNT_MAX = 10'd1023;
  localparam logic [RT_W-1:0]    RT_MAX    = 11'd2047;

  // Scorer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_RELEASE = 2'd2;

  function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [RT_W-1:0] sat_inc_rt(input logic [RT_W-1:0] v);
    return (v == RT_MAX) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser plus stability counter for the raw
// push-button. btn_db only changes after the synchronised level has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous active-high reset
//   button    in  raw asynchronous push-button (active-high)
//   btn_db    out debounced button level (registered)
//   btn_rise  out one-cycle pulse in the first cycle btn_db is high
module button_debouncer
  import led_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic btn_db,
  output logic btn_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_db_dly_q, btn_db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for synchroniser, stability counter and debounced level
  always_comb begin
    sync1_d      = button;
    sync2_d      = sync1_q;
    btn_db_d     = btn_db_q;
    btn_db_dly_d = btn_db_q;
    cnt_d        = cnt_q;
    if (sync2_q != btn_db_q) begin
      // Accept the new level only once it has persisted the full window
      if (cnt_q == CNT_LAST) begin
        btn_db_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign btn_db   = btn_db_q;
  assign btn_rise = btn_db_q & ~btn_db_dly_q;

endmodule

// File: rtl/led_response_scorer.sv
// led_response_scorer: measures the player's reaction to a lit LED in
// milliseconds, classifies each LED event as hit or miss and keeps
// saturating hit/miss tallies.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   enable       in   round active; low forces IDLE without scoring
//   led          in   LED state from the randomiser
//   button       in   raw asynchronous push-button
//   hit / miss   out  one-cycle registered score pulses
//   reaction_ms  out  reaction time of the last hit (ms)
//   hit_count    out  saturating hit tally
//   miss_count   out  saturating miss tally
module led_response_scorer
  import led_game_pkg::*;
#(
  parameter int MS_CYCLES       = 50000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_MS      = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               led,
  input  logic               button,
  output logic               hit,
  output logic               miss,
  output logic [RT_W-1:0]    reaction_ms,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  localparam int PS_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(MS_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_TIMEOUT = RT_W'(TIMEOUT_MS);

  logic btn_db;
  logic btn_rise;

  state_t             state_q, state_d;
  logic               led_q, led_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [RT_W-1:0]    rt_q, rt_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [RT_W-1:0]    reaction_q, reaction_d;
  logic [COUNT_W-1:0] hit_count_q, hit_count_d;
  logic [COUNT_W-1:0] miss_count_q, miss_count_d;

  logic ms_tick;
  logic led_rise;
  logic led_fall;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .button  (button),
    .btn_db  (btn_db),
    .btn_rise(btn_rise)
  );

  assign ms_tick  = (presc_q == PS_LAST);
  assign led_rise = led & ~led_q;
  assign led_fall = ~led & led_q;

  // FSM, prescaler, reaction timer and score next-state logic
  always_comb begin
    state_d      = state_q;
    led_d        = led;
    presc_d      = ms_tick ? '0 : presc_q + PS_W'(1);
    rt_d         = rt_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    reaction_d   = reaction_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (led_rise) begin
            // Restart the prescaler so reaction time truncates from entry
            state_d = ST_ARMED;
            rt_d    = '0;
            presc_d = '0;
          end else if (btn_rise && !led) begin
            miss_d       = 1'b1;
            miss_count_d = sat_inc_count(miss_count_q);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (ms_tick) begin
            rt_d = sat_inc_rt(rt_q);
          end else begin
            rt_d = rt_q;
          end
          // A press wins over a coincident timeout or LED fall
          if (btn_rise) begin
            state_d     = ST_RELEASE;
            hit_d       = 1'b1;
            reaction_d  = rt_q;
            hit_count_d = sat_inc_count(hit_count_q);
          end else if ((rt_q == RT_TIMEOUT) || led_fall) begin
            state_d      = ST_IDLE;
            miss_d       = 1'b1;
            miss_count_d = sat_inc_count(miss_count_q);
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_RELEASE: begin
          if (!btn_db) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RELEASE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      led_q        <= 1'b0;
      presc_q      <= '0;
      rt_q         <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      reaction_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      presc_q      <= presc_d;
      rt_q         <= rt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      reaction_q   <= reaction_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit         = hit_q;
  assign miss        = miss_q;
  assign reaction_ms = reaction_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_led_response_scorer.sv
// tb_led_response_scorer: randomised and directed rounds; a reference model
// predicts each score pulse (kind, cycle, reaction, tallies) into a queue that
// a negedge monitor pops and compares whenever hit or miss is seen.
module tb_led_response_scorer;

  localparam int MS  = 10;
  localparam int DB  = 4;
  localparam int TO  = 5;
  localparam int BIG = 1000000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        led = 1'b0;
  logic        button = 1'b0;
  logic        hit;
  logic        miss;
  logic [10:0] reaction_ms;
  logic [9:0]  hit_count;
  logic [9:0]  miss_count;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    bit is_hit;
    int cyc;
    int rt;
    int hc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  int   m_hc = 0;
  int   m_mc = 0;
  int   m_rt = 0;

  led_response_scorer #(
    .MS_CYCLES(MS),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_MS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .led(led),
    .button(button),
    .hit(hit),
    .miss(miss),
    .reaction_ms(reaction_ms),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Predict one score pulse visible after edge c
  task automatic push(input bit h, input int c, input int rt);
    exp_t e;
    if (h) begin
      m_hc = (m_hc < 1023) ? m_hc + 1 : 1023;
      m_rt = rt;
    end else begin
      m_mc = (m_mc < 1023) ? m_mc + 1 : 1023;
    end
    e.is_hit = h;
    e.cyc    = c;
    e.rt     = m_rt;
    e.hc     = m_hc;
    e.mc     = m_mc;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (hit || miss) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse hit=%0b miss=%0b expected=none (cycle %0d)", hit, miss, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_hit", hit, e.is_hit);
          chk("pulse_kind_miss", miss, !e.is_hit);
          chk("pulse_cycle", cyc, e.cyc);
          chk("reaction_ms", reaction_ms, e.rt);
          chk("hit_count", hit_count, e.hc);
          chk("miss_count", miss_count, e.mc);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse actual=none expected_hit=%0b at cycle %0d", exp_q[0].is_hit, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // One LED round. pd/fd: press / LED-fall delay in cycles after the LED
  // rises (-1 = never). With bounce the button chatters before the press.
  task automatic round(input int pd, input int fd, input bit bounce);
    int n, a, t, p, f, endc, last, span;
    n = cyc;
    led = 1'b1;
    a = n + 1;                       // ARMED entry edge
    t = a + TO * MS;                 // edge after which the timeout is seen
    p = (pd >= 0) ? n + pd + DB + 2 : BIG;  // edge after which the press is seen
    f = (fd >= 0) ? n + fd : BIG;    // edge after which the LED fall is seen
    endc = min2(p, min2(t, f));
    if (p == endc) begin
      push(1'b1, p + 1, (p - a) / MS);
      last = p + 1;
    end else begin
      push(1'b0, endc + 1, 0);
      last = endc + 1;
      if (p != BIG && f <= p) begin
        push(1'b0, p + 1, 0);        // press in IDLE with LED dark
        last = p + 1;
      end
    end
    span = max2(last - n, max2(pd, fd)) + 3;
    for (int k = 1; k <= span; k++) begin
      tick();
      if (bounce && k >= 2 && k <= 20 && (k % 2 == 0)) button = ~button;
      if (k == pd) button = 1'b1;
      if (k == fd) led = 1'b0;
    end
    button = 1'b0;
    repeat (DB + 6) tick();
    led = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_hit", hit, 0);
    chk("reset_miss", miss, 0);
    chk("reset_reaction", reaction_ms, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);

    // Clean hit: press 25 cycles after LED rise -> 3 ms
    round(25, -1, 1'b0);
    // Bouncing button, then stable press
    round(22, -1, 1'b1);
    // Timeout with a late press that must not score
    round(58, -1, 1'b0);
    round(-1, -1, 1'b0);

    // False press with LED dark
    begin
      int m;
      m = cyc;
      button = 1'b1;
      push(1'b0, m + DB + 3, 0);
      repeat (DB + 8) tick();
      button = 1'b0;
      repeat (DB + 6) tick();
    end

    // Press lands on the timeout cycle -> hit with 5 ms
    round(45, -1, 1'b0);

    // Enable drop while ARMED: no pulse, later press ignored
    led = 1'b1;
    repeat (10) tick();
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    repeat (60) tick();
    button = 1'b1;
    repeat (DB + 6) tick();
    button = 1'b0;
    repeat (DB + 6) tick();
    led = 1'b0;
    repeat (3) tick();

    // Randomised rounds
    for (int r = 0; r < 40; r++) begin
      int pd, fd;
      pd = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(60, 1));
      fd = ($urandom_range(2, 0) == 0) ? int'($urandom_range(60, 1)) : -1;
      round(pd, fd, 1'b0);
    end
    chk("queue_drained_random", exp_q.size(), 0);

    // Reset mid-ARMED discards the round
    led = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    led = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    m_hc = 0;
    m_mc = 0;
    m_rt = 0;
    tick();
    chk("midreset_hit", hit, 0);
    chk("midreset_miss", miss, 0);
    chk("midreset_reaction", reaction_ms, 0);
    chk("midreset_hit_count", hit_count, 0);
    chk("midreset_miss_count", miss_count, 0);
    repeat (60) tick();

    // Saturation: 1023 hits, then one more
    for (int r = 0; r < 1024; r++) round(1, -1, 1'b0);
    chk("sat_hit_count", hit_count, 1023);
    chk("sat_miss_count", miss_count, 0);

    repeat (5) tick();
    chk("queue_drained_final", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
